// File: rtl/rast_params.sv
// Shared rasterizer parameters and the triangle word carried from issue to rast.
package rast_params;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;

  typedef struct packed {
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
    logic [COLORS-1:0][SIGFIG-1:0]          color;
    logic                                   last;
  } tri_word_t;

  localparam int unsigned TRI_WORD_W = $bits(tri_word_t);

endpackage

// File: rtl/tri_fifo.sv
// Width-generic circular FIFO with registered full/empty/count and a combinational head read.
module tri_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_c_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A full FIFO may still take a push when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/tri_issue.sv
// Buffers upstream triangles and issues them to rast through a stall-aware output register,
// counting issued triangles per frame and pulsing frame_done_H on the last one.
module tri_issue #(
  parameter int unsigned SIGFIG = rast_params::SIGFIG,
  parameter int unsigned VERTS  = rast_params::VERTS,
  parameter int unsigned AXIS   = rast_params::AXIS,
  parameter int unsigned COLORS = rast_params::COLORS,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] in_tri_S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] in_color_U [COLORS],
  input  logic                     in_last_H,
  input  logic                     in_valid_H,
  output logic                     in_ready_H,
  input  logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R10U [COLORS],
  output logic                     validTri_R10H,
  output logic [31:0]              tri_count_U,
  output logic                     frame_done_H
);

  localparam int unsigned TRI_W   = SIGFIG * VERTS * AXIS;
  localparam int unsigned COL_W   = SIGFIG * COLORS;
  localparam int unsigned WORD_W  = TRI_W + COL_W + 1;
  localparam int unsigned COL_LSB = 1;
  localparam int unsigned TRI_LSB = COL_W + 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] head_word;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       count_q, count_d;
  logic              frame_done_q, frame_done_d;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop, xfer;

  // Flatten the upstream triangle into one word: {tri, color, last}.
  always_comb begin
    in_word = '0;
    for (int v = 0; v < int'(VERTS); v++) begin
      for (int a = 0; a < int'(AXIS); a++) begin
        in_word[TRI_LSB + (v * AXIS + a) * SIGFIG +: SIGFIG] = in_tri_S[v][a];
      end
    end
    for (int c = 0; c < int'(COLORS); c++) begin
      in_word[COL_LSB + c * SIGFIG +: SIGFIG] = in_color_U[c];
    end
    in_word[0] = in_last_H;
  end

  assign in_ready_H = rst & ~fifo_full;
  assign push       = in_valid_H & in_ready_H;
  assign xfer       = out_valid_q & halt_RnnnnL;
  assign pop        = ~fifo_empty & (~out_valid_q | xfer);

  tri_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .push_i    (push),
    .wdata_i   (in_word),
    .pop_i     (pop),
    .rdata_c_o (head_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Output register: refill from the head when empty or leaving; clear data when going idle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    if (xfer) begin
      out_valid_d  = 1'b0;
      out_word_d   = '0;
      frame_done_d = out_word_q[0];
      count_d      = out_word_q[0] ? 32'd0 : count_q + 32'd1;
    end
    if (pop) begin
      out_valid_d = 1'b1;
      out_word_d  = head_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Occupancy sanity: the FIFO count never exceeds DEPTH and agrees with its full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (fifo_count <= CNT_W'(DEPTH) && (fifo_full == (fifo_count == CNT_W'(DEPTH))));
    end
  end

  always_comb begin
    for (int v = 0; v < int'(VERTS); v++) begin
      for (int a = 0; a < int'(AXIS); a++) begin
        tri_R10S[v][a] = out_word_q[TRI_LSB + (v * AXIS + a) * SIGFIG +: SIGFIG];
      end
    end
    for (int c = 0; c < int'(COLORS); c++) begin
      color_R10U[c] = out_word_q[COL_LSB + c * SIGFIG +: SIGFIG];
    end
  end

  assign validTri_R10H = out_valid_q;
  assign tri_count_U   = count_q;
  assign frame_done_H  = frame_done_q;

endmodule
